// File: rtl/sha3_msg_padder.sv
// Packs a byte stream into SHA3 rate blocks with pad10*1 + DS byte and feeds the core; blk_valid is registered, one cycle after the issue condition.
// Backpressure: data_ready drops in SEND/DIGEST. SHA3_PADDER_LEN_CNT_EN adds the msg_len byte counter output.
module sha3_msg_padder #(
    parameter int         RATE_BYTES = 136,
    parameter logic [7:0] DS_BYTE    = 8'h06
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                data_in,
    input  logic                      data_valid,
    input  logic                      data_last,
    output logic                      data_ready,
    output logic [8*RATE_BYTES-1:0]   blk,
    output logic                      blk_more,
    output logic                      blk_valid,
    input  logic                      core_hash_next,
    input  logic                      core_out_valid,
    output logic                      busy
`ifdef SHA3_PADDER_LEN_CNT_EN
    ,
    output logic [63:0]               msg_len
`endif
);

    localparam int BLK_W = 8 * RATE_BYTES;
    localparam int CNT_W = $clog2(RATE_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_BYTES - 1);

    typedef enum logic [1:0] {FILL, SEND, DIGEST} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             next_more;
    logic             pend_pad;
    logic             core_idle;

    logic             accept;
    logic [BLK_W-1:0] byte_vec;
    logic [BLK_W-1:0] pad_vec;
    logic [BLK_W-1:0] pad_blk;

    function automatic logic [7:0] bit_rev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Byte k sits at the top of the block, bit-reversed, so the core sees byte bit 0 first.
    function automatic logic [BLK_W-1:0] place(input logic [7:0] b, input logic [CNT_W-1:0] idx);
        logic [BLK_W-1:0] v;
        v = '0;
        v[BLK_W-1 -: 8] = bit_rev(b);
        return v >> {idx, 3'b000};
    endfunction

    always_comb begin
        accept   = data_valid && data_ready;
        byte_vec = place(data_in, cnt);
        pad_vec  = place(DS_BYTE, cnt + 1'b1) | place(8'h80, LAST_IDX);
        pad_blk  = place(DS_BYTE, '0) | place(8'h80, LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            cnt        <= '0;
            blk        <= '0;
            blk_valid  <= 1'b0;
            blk_more   <= 1'b0;
            data_ready <= 1'b1;
            busy       <= 1'b0;
            next_more  <= 1'b0;
            pend_pad   <= 1'b0;
            core_idle  <= 1'b1;
`ifdef SHA3_PADDER_LEN_CNT_EN
            msg_len    <= '0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        busy <= 1'b1;
                        cnt  <= cnt + 1'b1;
`ifdef SHA3_PADDER_LEN_CNT_EN
                        msg_len <= busy ? msg_len + 64'd1 : 64'd1;
`endif
                        if (data_last && cnt != LAST_IDX) begin
                            blk        <= blk | byte_vec | pad_vec;
                            next_more  <= 1'b0;
                            state      <= SEND;
                            data_ready <= 1'b0;
                        end else begin
                            blk <= blk | byte_vec;
                            if (cnt == LAST_IDX) begin
                                // A message ending exactly on a block boundary needs a pad-only block.
                                next_more  <= 1'b1;
                                pend_pad   <= data_last;
                                state      <= SEND;
                                data_ready <= 1'b0;
                            end
                        end
                    end
                end
                SEND: begin
                    if (blk_valid) begin
                        blk_valid <= 1'b0;
                        cnt       <= '0;
                        core_idle <= 1'b0;
                        if (!next_more) begin
                            blk   <= '0;
                            state <= DIGEST;
                        end else if (pend_pad) begin
                            blk       <= pad_blk;
                            pend_pad  <= 1'b0;
                            next_more <= 1'b0;
                        end else begin
                            blk        <= '0;
                            state      <= FILL;
                            data_ready <= 1'b1;
                        end
                    end else if (core_idle || core_hash_next) begin
                        blk_valid <= 1'b1;
                        blk_more  <= next_more;
                    end
                end
                DIGEST: begin
                    if (core_out_valid) begin
                        core_idle  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= FILL;
                        data_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= FILL;
                    data_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
